// File: rtl/as2650_io_resp.sv
// as2650_io_resp -- device end of the AS2650 external bus for extended I/O.
//
// Decodes REDE/WRTE cycles in an 8-byte window of the I/O page at BASE_ADDR
// and provides:
//   offset 0 GPIO_OUT (R/W)
//   offset 1 GPIO_IN  (RO, two-flop synchronised gpio_in)
//   offset 2 RELOAD   (R/W)
//   offset 3 CTRL     bit0 EN, bit1 FLAG (write 1 clears), bit2 SENSE_SEL,
//                     bit3 EDGE_SENSE (optional feature only)
//   offset 4 EDGE     rising-edge latch, write 1 clears (optional feature only)
//
// Optional feature macro: AS2650_RESP_EDGE_EN
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   adr[12:0]               CPU address; only adr[7:0] is decoded
//   dbus_in[7:0]            CPU write data
//   m_io, d_c, rw, wrp, opreq  bus cycle qualifiers (d_c unused)
//   dbus_out[7:0], dbus_oe  registered read data and drive enable
//   sense_out               flag routed to the CPU sense input (registered)
//   gpio_in[7:0]            asynchronous inputs
//   gpio_out[7:0]           output latch
module as2650_io_resp #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         PRESCALE  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] adr,
  input  logic [7:0]  dbus_in,
  input  logic        m_io,
  input  logic        d_c,
  input  logic        rw,
  input  logic        wrp,
  input  logic        opreq,
  output logic [7:0]  dbus_out,
  output logic        dbus_oe,
  output logic        sense_out,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  // Upper address bits and d_c carry no information for this responder.
  logic unused_bits;
  assign unused_bits = ^{adr[12:8], d_c};

  logic          sel, wr_en, tick;
  logic [2:0]    off;
  logic          wr_gpio, wr_reload, wr_ctrl;

  logic [7:0]    gpio_out_q, reload_q, count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          en_q, flag_q, flag_d, ssel_q;
  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    dout_q, rd_data;
  logic          oe_q, rd_valid, rd_hit, sense_q, sense_d;
  logic          esense_bit;

  assign sel       = opreq & ~m_io & (adr[7:3] == BASE_ADDR[7:3]);
  assign off       = adr[2:0];
  assign wr_en     = sel & rw & wrp;
  assign wr_gpio   = wr_en & (off == 3'd0);
  assign wr_reload = wr_en & (off == 3'd2);
  assign wr_ctrl   = wr_en & (off == 3'd3);

`ifdef AS2650_RESP_EDGE_EN
  logic [7:0] edge_q, edge_d, sync_prev_q;
  logic       esense_q, wr_edge;
  assign wr_edge    = wr_en & (off == 3'd4);
  assign esense_bit = esense_q;
  // A rising edge seen in the same cycle as a clear keeps its bit set.
  assign edge_d = (edge_q & ~({8{wr_edge}} & dbus_in)) | (sync2_q & ~sync_prev_q);
`else
  assign esense_bit = 1'b0;
`endif

  // Timer: prescaler wraps at PRESCALE-1 to produce a tick; the 8-bit counter
  // decrements per tick and reloads (raising FLAG) when a tick finds it at 0.
  assign tick = en_q & (presc_q == PRESC_MAX);

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    flag_d  = flag_q;
    if (wr_ctrl & dbus_in[1]) flag_d = 1'b0;
    if (en_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (count_q == 8'd0) begin
          count_d = reload_q;
          flag_d  = 1'b1;  // overrides a same-cycle clear
        end else begin
          count_d = count_q - 8'd1;
        end
      end
    end
    // Enabling from the stopped state restarts a full period.
    if (wr_ctrl & dbus_in[0] & ~en_q) begin
      count_d = reload_q;
      presc_d = '0;
    end
  end

  // Read mux over the live register values.
  always_comb begin
    rd_valid = 1'b1;
    rd_data  = 8'h00;
    case (off)
      3'd0: rd_data = gpio_out_q;
      3'd1: rd_data = sync2_q;
      3'd2: rd_data = reload_q;
      3'd3: rd_data = {4'b0000, esense_bit, ssel_q, flag_q, en_q};
`ifdef AS2650_RESP_EDGE_EN
      3'd4: rd_data = edge_q;
`endif
      default: rd_valid = 1'b0;
    endcase
  end

  assign rd_hit = sel & ~rw & rd_valid;

`ifdef AS2650_RESP_EDGE_EN
  assign sense_d = (ssel_q & flag_q) | (esense_q & (|edge_q));
`else
  assign sense_d = ssel_q & flag_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= 8'h00;
      reload_q   <= 8'hFF;
      en_q       <= 1'b0;
      flag_q     <= 1'b0;
      ssel_q     <= 1'b0;
      count_q    <= 8'h00;
      presc_q    <= '0;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      dout_q     <= 8'h00;
      oe_q       <= 1'b0;
      sense_q    <= 1'b0;
`ifdef AS2650_RESP_EDGE_EN
      edge_q      <= 8'h00;
      sync_prev_q <= 8'h00;
      esense_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (wr_gpio)   gpio_out_q <= dbus_in;
      if (wr_reload) reload_q   <= dbus_in;
      if (wr_ctrl) begin
        en_q   <= dbus_in[0];
        ssel_q <= dbus_in[2];
      end
      count_q <= count_d;
      presc_q <= presc_d;
      flag_q  <= flag_d;
      oe_q    <= rd_hit;
      dout_q  <= rd_hit ? rd_data : 8'h00;
      sense_q <= sense_d;
`ifdef AS2650_RESP_EDGE_EN
      sync_prev_q <= sync2_q;
      edge_q      <= edge_d;
      if (wr_ctrl) esense_q <= dbus_in[3];
`endif
    end
  end

  assign gpio_out  = gpio_out_q;
  assign dbus_out  = dout_q;
  assign dbus_oe   = oe_q;
  assign sense_out = sense_q;

endmodule

// File: tb/tb_as2650_io_resp.sv
module tb_as2650_io_resp;

  localparam int TP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] adr = '0;
  logic [7:0]  dbus_in = '0;
  logic        m_io = 1'b0;
  logic        d_c = 1'b0;
  logic        rw = 1'b0;
  logic        wrp = 1'b0;
  logic        opreq = 1'b0;
  logic [7:0]  dbus_out;
  logic        dbus_oe;
  logic        sense_out;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference state of the writable registers.
  logic [7:0] m_gpio = 8'h00;
  logic [7:0] m_reload = 8'hFF;
  logic [7:0] m_ctrl = 8'h00;

  as2650_io_resp #(.BASE_ADDR(8'hF0), .PRESCALE(TP)) dut (
    .clk(clk), .reset(reset), .adr(adr), .dbus_in(dbus_in), .m_io(m_io),
    .d_c(d_c), .rw(rw), .wrp(wrp), .opreq(opreq), .dbus_out(dbus_out),
    .dbus_oe(dbus_oe), .sense_out(sense_out), .gpio_in(gpio_in),
    .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [7:0] d);
    adr = a; dbus_in = d; m_io = 1'b0; rw = 1'b1; wrp = 1'b1; opreq = 1'b1;
    step();
    opreq = 1'b0; wrp = 1'b0; rw = 1'b0;
    $display("write adr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [12:0] a, output logic [7:0] d, output logic o);
    adr = a; m_io = 1'b0; rw = 1'b0; wrp = 1'b0; opreq = 1'b1;
    step();
    d = dbus_out; o = dbus_oe;
    opreq = 1'b0;
    step();
    $display("read  adr=%h data=%h oe=%0d", a, d, o);
  endtask

  task automatic test_reset();
    logic [7:0] d; logic o;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio got=%h exp=00", gpio_out); end
    checks++; if (dbus_oe !== 1'b0 || dbus_out !== 8'h00) begin errors++; $display("FAIL reset_bus got oe=%b d=%h exp oe=0 d=00", dbus_oe, dbus_out); end
    checks++; if (sense_out !== 1'b0) begin errors++; $display("FAIL reset_sense got=%b exp=0", sense_out); end
    bus_read(13'h0F2, d, o);
    checks++; if (o !== 1'b1 || d !== 8'hFF) begin errors++; $display("FAIL reset_reload got oe=%b d=%h exp oe=1 d=FF", o, d); end
    bus_read(13'h0F3, d, o);
    checks++; if (o !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got oe=%b d=%h exp oe=1 d=00", o, d); end
  endtask

  task automatic test_basic_rw();
    bus_write(13'h0F0, 8'hA5);
    m_gpio = 8'hA5;
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_write got=%h exp=A5", gpio_out); end
    adr = 13'h0F0; rw = 1'b0; m_io = 1'b0; opreq = 1'b1;
    #1;
    checks++; if (dbus_oe !== 1'b0) begin errors++; $display("FAIL read_latency got oe=%b exp=0", dbus_oe); end
    step();
    checks++; if (dbus_oe !== 1'b1 || dbus_out !== 8'hA5) begin errors++; $display("FAIL read_gpio got oe=%b d=%h exp oe=1 d=A5", dbus_oe, dbus_out); end
    opreq = 1'b0;
    step();
    checks++; if (dbus_oe !== 1'b0 || dbus_out !== 8'h00) begin errors++; $display("FAIL read_release got oe=%b d=%h exp oe=0 d=00", dbus_oe, dbus_out); end
    $display("basic read/write done");
  endtask

  task automatic test_gpio_in();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h00; exp_seq[1] = 8'h00; exp_seq[2] = 8'h3C;
    gpio_in = 8'h3C;
    adr = 13'h0F1; rw = 1'b0; m_io = 1'b0; opreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dbus_oe !== 1'b1 || dbus_out !== exp_seq[i]) begin
        errors++; $display("FAIL gpio_in_sync[%0d] got oe=%b d=%h exp oe=1 d=%h", i, dbus_oe, dbus_out, exp_seq[i]);
      end
      $display("gpio_in read cycle %0d data=%h", i, dbus_out);
    end
    opreq = 1'b0;
    step();
    m_io = 1'b1; opreq = 1'b1;
    step(); step();
    checks++; if (dbus_oe !== 1'b0 || dbus_out !== 8'h00) begin errors++; $display("FAIL mem_cycle got oe=%b d=%h exp oe=0 d=00", dbus_oe, dbus_out); end
    opreq = 1'b0; m_io = 1'b0;
    step();
  endtask

  task automatic test_random_regs();
    logic [7:0] d, wd, m_in, exp_d; logic o, exp_o, base_ok; logic [2:0] off; logic [12:0] a;
    m_in = 8'($urandom);
    gpio_in = m_in;
    step(); step(); step();
    for (int i = 0; i < 40; i++) begin
      off = 3'($urandom_range(0, 7));
      base_ok = ($urandom_range(0, 3) != 0);
      a = base_ok ? {5'b0, 5'b11110, off} : {5'b0, 5'b11101, off};
`ifdef AS2650_RESP_EDGE_EN
      if (off == 3'd4) off = 3'd5;
      a[2:0] = off;
`endif
      if ($urandom_range(0, 1) == 1 && off != 3'd3) begin
        wd = 8'($urandom);
        bus_write(a, wd);
        if (base_ok && off == 3'd0) m_gpio = wd;
        if (base_ok && off == 3'd2) m_reload = wd;
        checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL rand_gpio_out got=%h exp=%h", gpio_out, m_gpio); end
      end else begin
        bus_read(a, d, o);
        exp_o = base_ok && (off <= 3'd3);
        case (off)
          3'd0: exp_d = m_gpio;
          3'd1: exp_d = m_in;
          3'd2: exp_d = m_reload;
          3'd3: exp_d = m_ctrl;
          default: exp_d = 8'h00;
        endcase
        if (!exp_o) exp_d = 8'h00;
        checks++;
        if (o !== exp_o || d !== exp_d) begin
          errors++; $display("FAIL rand_read adr=%h got oe=%b d=%h exp oe=%b d=%h", a, o, d, exp_o, exp_d);
        end
      end
    end
  endtask

  task automatic wait_sense_rise(input int exp_cyc, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (sense_out === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL %s timeout waiting for sense_out exp_cyc=%0d", name, exp_cyc); end
    else if (cyc != exp_cyc) begin errors++; $display("FAIL %s got cyc=%0d exp cyc=%0d", name, cyc, exp_cyc); end
    else $display("%s sense_out rose at cyc=%0d", name, cyc);
  endtask

  task automatic test_timer();
    logic [7:0] d; logic o; int c0, per;
    bus_write(13'h0F2, 8'h03); m_reload = 8'h03;
    bus_write(13'h0F3, 8'h05); m_ctrl = 8'h05;
    c0 = cyc;
    per = TP * (3 + 1);
    wait_sense_rise(c0 + per + 1, "timer_first");
    bus_read(13'h0F3, d, o);
    checks++; if (d !== 8'h07) begin errors++; $display("FAIL timer_flag_set got=%h exp=07", d); end
    bus_write(13'h0F3, 8'h07);
    bus_read(13'h0F3, d, o);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL timer_flag_clear got=%h exp=05", d); end
    wait_sense_rise(c0 + 2 * per + 1, "timer_repeat");
    bus_write(13'h0F3, 8'h07);
    // Land the next clear exactly on the edge where the timer reloads.
    for (int i = 0; i < 200 && cyc < c0 + 3 * per - 1; i++) step();
    checks++;
    if (cyc != c0 + 3 * per - 1) begin errors++; $display("FAIL timer_align got cyc=%0d exp=%0d", cyc, c0 + 3 * per - 1); end
    bus_write(13'h0F3, 8'h07);
    bus_read(13'h0F3, d, o);
    checks++; if (d !== 8'h07) begin errors++; $display("FAIL set_wins_ctrl got=%h exp=07", d); end
    checks++; if (sense_out !== 1'b1) begin errors++; $display("FAIL set_wins_sense got=%b exp=1", sense_out); end
  endtask

  task automatic test_timer_random();
    int r, c0;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 6);
      bus_write(13'h0F3, 8'h00);
      bus_write(13'h0F3, 8'h02);
      bus_write(13'h0F2, 8'(r)); m_reload = 8'(r);
      bus_write(13'h0F3, 8'h05); m_ctrl = 8'h05;
      c0 = cyc;
      wait_sense_rise(c0 + TP * (r + 1) + 1, "timer_rand");
    end
  endtask

  task automatic test_undecoded();
    logic [7:0] d; logic o;
    bus_read(13'h0F5, d, o);
    checks++; if (o !== 1'b0 || d !== 8'h00) begin errors++; $display("FAIL undec_read_F5 got oe=%b d=%h exp oe=0 d=00", o, d); end
    bus_read(13'h0E0, d, o);
    checks++; if (o !== 1'b0 || d !== 8'h00) begin errors++; $display("FAIL undec_read_E0 got oe=%b d=%h exp oe=0 d=00", o, d); end
    bus_write(13'h0F5, 8'h55);
    bus_write(13'h0E0, 8'h5A);
    bus_write(13'h0E2, 8'h11);
    checks++; if (gpio_out !== m_gpio) begin errors++; $display("FAIL undec_write_gpio got=%h exp=%h", gpio_out, m_gpio); end
    bus_read(13'h0F2, d, o);
    checks++; if (d !== m_reload) begin errors++; $display("FAIL undec_write_reload got=%h exp=%h", d, m_reload); end
  endtask

`ifdef AS2650_RESP_EDGE_EN
  task automatic test_edge();
    logic [7:0] d; logic o;
    gpio_in = 8'h00;
    bus_write(13'h0F3, 8'h08);
    step(); step(); step();
    bus_write(13'h0F4, 8'hFF);
    bus_read(13'h0F4, d, o);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_cleared got=%h exp=00", d); end
    checks++; if (sense_out !== 1'b0) begin errors++; $display("FAIL edge_sense_idle got=%b exp=0", sense_out); end
    gpio_in = 8'h04;
    step(); step(); step();
    gpio_in = 8'h00;
    step(); step();
    bus_read(13'h0F4, d, o);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL edge_latch got=%h exp=04", d); end
    checks++; if (sense_out !== 1'b1) begin errors++; $display("FAIL edge_sense got=%b exp=1", sense_out); end
    bus_write(13'h0F4, 8'h04);
    step();
    bus_read(13'h0F4, d, o);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_clear got=%h exp=00", d); end
    checks++; if (sense_out !== 1'b0) begin errors++; $display("FAIL edge_sense_clear got=%b exp=0", sense_out); end
  endtask
`endif

  task automatic test_reset_midcycle();
    logic [7:0] d; logic o;
    adr = 13'h0F0; rw = 1'b0; m_io = 1'b0; opreq = 1'b1;
    step();
    checks++; if (dbus_oe !== 1'b1) begin errors++; $display("FAIL midreset_pre got oe=%b exp=1", dbus_oe); end
    reset = 1'b1;
    step();
    checks++; if (dbus_oe !== 1'b0) begin errors++; $display("FAIL midreset_oe got oe=%b exp=0", dbus_oe); end
    dbus_in = 8'h5A; rw = 1'b1; wrp = 1'b1;
    step();
    reset = 1'b0; opreq = 1'b0; wrp = 1'b0; rw = 1'b0;
    step();
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL midreset_write got=%h exp=00", gpio_out); end
    bus_read(13'h0F2, d, o);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL midreset_reload got=%h exp=FF", d); end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_gpio_in();
    test_random_regs();
    test_timer();
    test_timer_random();
    test_undecoded();
`ifdef AS2650_RESP_EDGE_EN
    test_edge();
`endif
    test_reset_midcycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
